// File: rtl/python_pkg.sv
// Shared constants and types for the Python sensor word aligner.
package python_pkg;

  // Training word sent on every lane while the link is idle.
  localparam logic [9:0] TRAIN_WORD = 10'h3a6;

  // Sync-channel codes the sensor can place on lane 4.
  localparam logic [7:0][9:0] SYNC_CODES = {
    10'h059, 10'h035, 10'h0aa, 10'h3aa,
    10'h2aa, 10'h12a, 10'h015, 10'h22a
  };

  // Global alignment state.
  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

  // Bit-slip step: shifts run 0..9 and wrap.
  function automatic logic [3:0] next_shift(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd0 : s + 4'd1;
  endfunction

endpackage

// File: rtl/python_lane_align.sv
// One lane of the word aligner: previous-word register, barrel shift over the
// 20-bit {current, previous} window, training-match counter and shift register.
module python_lane_align
  import python_pkg::*;
#(
  parameter int LOCK_COUNT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cke,
  input  logic       s_valid,
  input  logic       search,
  input  logic       clear,
  input  logic [9:0] s_word,
  output logic [9:0] a_word,
  output logic       done,
  output logic [3:0] shift
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_COUNT);

  logic [9:0]    prev_q, prev_d;
  logic [3:0]    shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match;

  assign done  = (cnt_q == CNT_MAX);
  assign shift = shift_q;

  // Aligned word and next lane state; a done lane keeps its shift and count.
  always_comb begin
    a_word  = 10'({s_word, prev_q} >> shift_q);
    match   = (a_word == TRAIN_WORD);
    prev_d  = prev_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (s_valid) begin
      prev_d = s_word;
    end
    if (clear) begin
      shift_d = 4'd0;
      cnt_d   = '0;
    end else if (s_valid && search && !done) begin
      if (match) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d   = '0;
        shift_d = next_shift(shift_q);
      end
    end
  end

  // Lane registers; reset overrides the clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (cke) begin
      prev_q  <= prev_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/python_word_align.sv
// Five-lane word aligner for the Python image sensor (4 pixel lanes + sync).
// Global SEARCH/LOCKED machine, optional lock-loss watchdog and output regs.
// Define PYTHON_WORD_ALIGN_TIMEOUT_EN to build in the watchdog.
module python_word_align
  import python_pkg::*;
#(
  parameter int LOCK_COUNT = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cke,
  input  logic [4:0][9:0] s_data,
  input  logic            s_valid,
  input  logic            relock,
  output logic [3:0][9:0] m_data,
  output logic [9:0]      m_sync,
  output logic            m_valid,
  output logic            locked,
  output logic [4:0][3:0] lane_shift
);

  align_state_e    state_q, state_d;
  logic [4:0][9:0] aligned;
  logic [4:0]      lane_done;
  logic            lane_search;
  logic            lane_clear;
  logic            wd_fire;
  logic [3:0][9:0] m_data_q, m_data_d;
  logic [9:0]      m_sync_q, m_sync_d;
  logic            m_valid_q, m_valid_d;
  logic            locked_q, locked_d;

  assign lane_search = (state_q == ST_SEARCH);
  assign lane_clear  = relock | wd_fire;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_lane
      python_lane_align #(
        .LOCK_COUNT(LOCK_COUNT)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .cke    (cke),
        .s_valid(s_valid),
        .search (lane_search),
        .clear  (lane_clear),
        .s_word (s_data[gi]),
        .a_word (aligned[gi]),
        .done   (lane_done[gi]),
        .shift  (lane_shift[gi])
      );
    end
  endgenerate

`ifdef PYTHON_WORD_ALIGN_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            sync_match;

  assign sync_match = (aligned[4] == TRAIN_WORD);

  // Count locked beats since the last sync-lane training word; fire on the last one.
  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (state_q != ST_LOCKED || relock) begin
      wd_d = '0;
    end else if (s_valid) begin
      if (sync_match) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST) begin
        wd_d    = '0;
        wd_fire = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else if (cke) begin
      wd_q <= wd_d;
    end
  end
`else
  logic timeout_unused;
  assign wd_fire        = 1'b0;
  assign timeout_unused = (TIMEOUT != 0);
`endif

  // Next state and output values; relock always wins over lock completion.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_SEARCH) begin
      if (&lane_done) begin
        state_d = ST_LOCKED;
      end
    end else if (wd_fire) begin
      state_d = ST_SEARCH;
    end
    if (relock) begin
      state_d = ST_SEARCH;
    end
    m_valid_d = s_valid && (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    m_data_d  = m_data_q;
    m_sync_d  = m_sync_q;
    if (m_valid_d) begin
      m_data_d = aligned[3:0];
      m_sync_d = aligned[4];
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs; reset overrides the clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      m_data_q  <= '0;
      m_sync_q  <= '0;
      m_valid_q <= 1'b0;
      locked_q  <= 1'b0;
    end else if (cke) begin
      state_q   <= state_d;
      m_data_q  <= m_data_d;
      m_sync_q  <= m_sync_d;
      m_valid_q <= m_valid_d;
      locked_q  <= locked_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_sync  = m_sync_q;
  assign m_valid = m_valid_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_python_word_align.sv
// Bench for python_word_align: a bit-serial model skews each lane, expected
// aligned words go into a scoreboard and are popped whenever m_valid is seen.
module tb_python_word_align;
  import python_pkg::*;

  localparam int LOCK_N = 16;
  localparam int TMO    = 64;
`ifdef PYTHON_WORD_ALIGN_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            cke;
  logic [4:0][9:0] s_data;
  logic            s_valid;
  logic            relock;
  logic [3:0][9:0] m_data;
  logic [9:0]      m_sync;
  logic            m_valid;
  logic            locked;
  logic [4:0][3:0] lane_shift;

  python_word_align #(
    .LOCK_COUNT(LOCK_N),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cke       (cke),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .relock    (relock),
    .m_data    (m_data),
    .m_sync    (m_sync),
    .m_valid   (m_valid),
    .locked    (locked),
    .lane_shift(lane_shift)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][9:0] words;
    logic            vld;
    logic            exp_valid;
  } vec_t;

  int              checks = 0;
  int              errors = 0;
  logic [4:0][9:0] sb[$];
  logic [4:0][9:0] pending;
  logic [4:0][3:0] skew;
  logic [4:0][9:0] w5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Pop one expected beat for every m_valid the DUT shows.
  task automatic monitor();
    logic [4:0][9:0] e;
    if (m_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_valid_unexpected: got m_valid=1 expected no output");
      end else begin
        e = sb.pop_front();
        chk("m_sync_m_data", {m_sync, m_data}, e);
      end
    end
  endtask

  task automatic sync_edge();
    @(negedge clk);
    monitor();
  endtask

  // Serializer model: the aligned word of this beat is 'pending', the next is 'nxt'.
  task automatic drive(input logic [4:0][9:0] nxt, input logic vld, input logic exp_out,
                       input logic rl);
    logic [19:0] w;
    relock  = rl;
    s_valid = vld;
    for (int l = 0; l < 5; l++) begin
      if (vld) begin
        w = {nxt[l], pending[l]} >> (10 - skew[l]);
        s_data[l] = w[9:0];
      end else begin
        s_data[l] = 10'($urandom);
      end
    end
    if (vld && exp_out) sb.push_back(pending);
    if (vld) pending = nxt;
  endtask

  task automatic train_until_lock(output int n);
    n = -1;
    for (int i = 0; i <= 10 * (LOCK_N + 1); i++) begin
      sync_edge();
      if (locked === 1'b1) begin
        n = i;
        break;
      end
      if (i == 10 * (LOCK_N + 1)) break;
      drive(w5, 1'b1, 1'b0, 1'b0);
    end
    drive(w5, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic [4:0][9:0] w, input logic v, input logic e);
    vec_t r;
    r.words     = w;
    r.vld       = v;
    r.exp_valid = e;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t            tbl[13];
    logic [4:0][9:0] nx;
    logic [4:0][3:0] exp_shift;
    int              n;

    w5        = {5{TRAIN_WORD}};
    skew      = {4'd7, 4'd3, 4'd3, 4'd3, 4'd3};
    exp_shift = {4'd7, 4'd3, 4'd3, 4'd3, 4'd3};
    pending   = w5;

    tbl[0]  = mk({10'h035, 10'h30f, 10'h0f0, 10'h2aa, 10'h155}, 1'b1, 1'b1);
    tbl[1]  = mk({TRAIN_WORD, 10'h000, 10'h3ff, 10'h000, 10'h3ff}, 1'b1, 1'b1);
    tbl[2]  = mk({10'h111, 10'h222, 10'h333, 10'h044, 10'h055}, 1'b0, 1'b0);
    tbl[3]  = mk({SYNC_CODES[0], 10'h001, 10'h002, 10'h004, 10'h008}, 1'b1, 1'b1);
    tbl[4]  = mk({10'h0aa, 10'h0bb, 10'h0cc, 10'h0dd, 10'h0ee}, 1'b0, 1'b0);
    tbl[5]  = mk({TRAIN_WORD, 10'h155, 10'h2aa, 10'h155, 10'h2aa}, 1'b1, 1'b1);
    tbl[6]  = mk({SYNC_CODES[1], 10'h200, 10'h100, 10'h080, 10'h040}, 1'b1, 1'b1);
    tbl[7]  = mk({TRAIN_WORD, 10'h123, 10'h321, 10'h2d5, 10'h0b4}, 1'b1, 1'b1);
    tbl[8]  = mk({10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff, 10'h3ff}, 1'b0, 1'b0);
    tbl[9]  = mk({10'h000, 10'h000, 10'h000, 10'h000, 10'h000}, 1'b0, 1'b0);
    tbl[10] = mk({SYNC_CODES[2], 10'h0f0, 10'h30f, 10'h155, 10'h2aa}, 1'b1, 1'b1);
    tbl[11] = mk(w5, 1'b1, 1'b1);
    tbl[12] = mk(w5, 1'b1, 1'b1);

    // Reset state.
    reset = 1'b1; cke = 1'b1; s_valid = 1'b0; relock = 1'b0; s_data = '0;
    repeat (3) sync_edge();
    chk("rst_locked", locked, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_sync", m_sync, '0);
    chk("rst_lane_shift", lane_shift, '0);
    reset = 1'b0;
    drive(w5, 1'b0, 1'b0, 1'b0);

    // Initial training: lanes skewed 3, sync lane skewed 7.
    train_until_lock(n);
    chk("lock_found", (n >= 0 && n <= 10 * (LOCK_N + 1)), 1'b1);
    chk("lock_beats", n, 24);
    chk("lock_shifts", lane_shift, exp_shift);
    chk("lock_locked", locked, 1'b1);

    // Table: data words, sync codes and gap beats while locked.
    for (int i = 0; i < 13; i++) begin
      sync_edge();
      if (i > 0) chk("tbl_m_valid", m_valid, tbl[i-1].exp_valid);
      drive(tbl[i].words, tbl[i].vld, 1'b1, 1'b0);
    end
    sync_edge();
    chk("tbl_m_valid", m_valid, tbl[12].exp_valid);
    drive(w5, 1'b0, 1'b0, 1'b0);
    sync_edge();
    drive(w5, 1'b0, 1'b0, 1'b0);
    chk("tbl_drained", sb.size(), 0);

    // Relock while locked, with a clock-enable hold in the middle of the search.
    sync_edge();
    drive(w5, 1'b1, 1'b0, 1'b1);
    sync_edge();
    chk("relock_locked", locked, 1'b0);
    chk("relock_m_valid", m_valid, 1'b0);
    chk("relock_shifts", lane_shift, '0);
    drive(w5, 1'b1, 1'b0, 1'b0);
    sync_edge();
    drive(w5, 1'b1, 1'b0, 1'b0);
    sync_edge();
    chk("search_shifts_2", lane_shift, {5{4'd2}});
    for (int i = 0; i < 3; i++) begin
      cke = 1'b0;
      drive(w5, 1'b0, 1'b0, 1'b0);
      s_valid = 1'b1;
      sync_edge();
    end
    chk("cke_hold_shifts", lane_shift, {5{4'd2}});
    cke = 1'b1;
    drive(w5, 1'b0, 1'b0, 1'b0);
    train_until_lock(n);
    chk("relock_beats", n, 22);
    chk("relock_again_shifts", lane_shift, exp_shift);

    // Relock coincident with the final matching beat of the sync lane.
    sync_edge();
    drive(w5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 22; i++) begin
      sync_edge();
      drive(w5, 1'b1, 1'b0, 1'b0);
    end
    sync_edge();
    drive(w5, 1'b1, 1'b0, 1'b1);
    sync_edge();
    chk("final_beat_relock_locked", locked, 1'b0);
    drive(w5, 1'b0, 1'b0, 1'b0);
    sync_edge();
    chk("final_beat_relock_locked2", locked, 1'b0);
    chk("final_beat_relock_shifts", lane_shift, '0);
    drive(w5, 1'b0, 1'b0, 1'b0);
    train_until_lock(n);
    chk("retrain1_beats", n, 24);

    // Relock in the cycle the lock would complete.
    sync_edge();
    drive(w5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 23; i++) begin
      sync_edge();
      drive(w5, 1'b1, 1'b0, 1'b0);
    end
    sync_edge();
    drive(w5, 1'b1, 1'b0, 1'b1);
    sync_edge();
    chk("complete_relock_locked", locked, 1'b0);
    drive(w5, 1'b0, 1'b0, 1'b0);
    sync_edge();
    chk("complete_relock_locked2", locked, 1'b0);
    drive(w5, 1'b0, 1'b0, 1'b0);
    train_until_lock(n);
    chk("retrain2_beats", n, 24);

    // Reset while locked with the clock enable low.
    sync_edge();
    drive(w5, 1'b1, 1'b1, 1'b0);
    sync_edge();
    reset = 1'b1;
    cke   = 1'b0;
    drive(w5, 1'b0, 1'b0, 1'b0);
    sync_edge();
    chk("lrst_locked", locked, 1'b0);
    chk("lrst_m_valid", m_valid, 1'b0);
    chk("lrst_m_data", m_data, '0);
    chk("lrst_m_sync", m_sync, '0);
    chk("lrst_shifts", lane_shift, '0);
    reset = 1'b0;
    cke   = 1'b1;
    drive(w5, 1'b0, 1'b0, 1'b0);
    train_until_lock(n);
    chk("retrain3_beats", n, 24);

    // Sync lane stops carrying the training word.
    nx    = w5;
    nx[4] = SYNC_CODES[6];
    sync_edge();
    drive(nx, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < TMO - 1; i++) begin
      sync_edge();
      drive(nx, 1'b1, 1'b1, 1'b0);
    end
    sync_edge();
    chk("wd_before_limit", locked, 1'b1);
    drive(nx, 1'b1, !WD_ON, 1'b0);
    sync_edge();
    chk("wd_at_limit", locked, !WD_ON);
    drive(w5, 1'b0, 1'b0, 1'b0);
    sync_edge();
    drive(w5, 1'b0, 1'b0, 1'b0);
    sync_edge();
    chk("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
